// File: rtl/lpc_pkg.sv
// rtl/lpc_pkg.sv - LPC bus codes, response encodings and host FSM states
package lpc_pkg;

   localparam logic [3:0] LPC_START  = 4'h0;
   localparam logic [3:0] CYC_IO_RD  = 4'h0;
   localparam logic [3:0] CYC_IO_WR  = 4'h2;
   localparam logic [3:0] LAD_IDLE   = 4'hF;

   localparam logic [3:0] SYNC_READY = 4'b0000;
   localparam logic [3:0] SYNC_SHORT = 4'b0101;
   localparam logic [3:0] SYNC_LONG  = 4'b0110;
   localparam logic [3:0] SYNC_ERR   = 4'b1010;
   localparam logic [3:0] SYNC_NONE  = 4'b1111;

   localparam logic [1:0] RSP_OK       = 2'b00;
   localparam logic [1:0] RSP_SYNC_ERR = 2'b01;
   localparam logic [1:0] RSP_TIMEOUT  = 2'b10;

   typedef enum logic [3:0] {
      ST_IDLE, ST_START, ST_CYC, ST_ADDR, ST_WDATA, ST_HTAR0, ST_HTAR1,
      ST_SYNC, ST_RDATA, ST_TTAR, ST_FAIL, ST_DONE
   } lpc_state_t;

   // Address goes out most-significant nibble first
   function automatic logic [3:0] addr_nibble(input logic [15:0] addr, input logic [1:0] idx);
      case (idx)
         2'd0:    return addr[15:12];
         2'd1:    return addr[11:8];
         2'd2:    return addr[7:4];
         default: return addr[3:0];
      endcase
   endfunction

endpackage

// File: rtl/lpc_sync_timer.sv
// rtl/lpc_sync_timer.sv - consecutive wait/no-sync code counter with per-code limit flag
module lpc_sync_timer
   import lpc_pkg::*;
#(
   parameter int SHORT_WAIT_MAX = 8,
   parameter int LONG_WAIT_MAX  = 1023,
   parameter int NO_SYNC_MAX    = 3
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_active,
   input  logic [3:0] i_code,
   output logic       o_over
);

   logic [15:0] r_cnt;
   logic [3:0]  r_code;
   logic [15:0] w_next;
   logic [15:0] w_limit;
   logic        w_counted;

   // One run counter is enough: any change of code restarts the run at 1
   always_comb begin
      w_counted = 1'b1;
      w_limit   = 16'(SHORT_WAIT_MAX);
      case (i_code)
         SYNC_SHORT: w_limit = 16'(SHORT_WAIT_MAX);
         SYNC_LONG:  w_limit = 16'(LONG_WAIT_MAX);
         SYNC_NONE:  w_limit = 16'(NO_SYNC_MAX);
         default:    w_counted = 1'b0;
      endcase
      w_next = (i_code == r_code) ? r_cnt + 16'd1 : 16'd1;
      o_over = i_active && w_counted && (w_next > w_limit);
   end

   // Track the current run while the host sits in SYNC; forget it otherwise
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt  <= 16'd0;
         r_code <= SYNC_READY;
      end else if (!i_active) begin
         r_cnt  <= 16'd0;
         r_code <= SYNC_READY;
      end else begin
         r_code <= i_code;
         r_cnt  <= w_counted ? w_next : 16'd0;
      end
   end

endmodule

// File: rtl/lpc_host_cycle.sv
// rtl/lpc_host_cycle.sv - LPC I/O read/write host cycle engine; LPC_HOST_ABORT_EN adds LFRAME# abort on failure
module lpc_host_cycle
   import lpc_pkg::*;
#(
   parameter int SHORT_WAIT_MAX = 8,
   parameter int LONG_WAIT_MAX  = 1023,
   parameter int NO_SYNC_MAX    = 3
) (
   input  logic        LpcClock,
   input  logic        PciReset,
   input  logic        ReqValid,
   output logic        ReqReady,
   input  logic        ReqWrite,
   input  logic [15:0] ReqAddr,
   input  logic [7:0]  ReqData,
   output logic        RspValid,
   output logic [7:0]  RspData,
   output logic [1:0]  RspErr,
   output logic        LFrameN,
   inout  wire  [3:0]  LpcBus
);

   lpc_state_t  r_state;
   logic [2:0]  r_cnt;
   logic        r_write;
   logic [15:0] r_addr;
   logic [7:0]  r_wdata;
   logic [7:0]  r_rdata;
   logic [1:0]  r_err;
   logic        r_oe;
   logic [3:0]  r_lad;
   logic        r_lframe_n;
   logic        r_req_ready;
   logic        r_rsp_valid;
   logic [7:0]  r_rsp_data;
   logic [1:0]  r_rsp_err;

   logic        w_sync_active;
   logic        w_over;
   logic        w_known;
   logic        w_sync_fail;

   assign ReqReady = r_req_ready;
   assign RspValid = r_rsp_valid;
   assign RspData  = r_rsp_data;
   assign RspErr   = r_rsp_err;
   assign LFrameN  = r_lframe_n;
   assign LpcBus   = r_oe ? r_lad : 4'hz;

   assign w_sync_active = (r_state == ST_SYNC);

   lpc_sync_timer #(
      .SHORT_WAIT_MAX (SHORT_WAIT_MAX),
      .LONG_WAIT_MAX  (LONG_WAIT_MAX),
      .NO_SYNC_MAX    (NO_SYNC_MAX)
   ) u_sync_timer (
      .i_clk    (LpcClock),
      .i_rst_n  (PciReset),
      .i_active (w_sync_active),
      .i_code   (LpcBus),
      .o_over   (w_over)
   );

   // A SYNC cycle fails on an unknown code or on a wait run that outlasts its limit
   always_comb begin
      w_known = (LpcBus == SYNC_READY) || (LpcBus == SYNC_ERR) || (LpcBus == SYNC_SHORT) ||
                (LpcBus == SYNC_LONG)  || (LpcBus == SYNC_NONE);
      w_sync_fail = w_sync_active && (w_over || !w_known);
   end

   // Frame sequencer; every bus output is loaded for the state being entered
   always_ff @(posedge LpcClock or negedge PciReset) begin
      if (!PciReset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 3'd0;
         r_write     <= 1'b0;
         r_addr      <= 16'h0000;
         r_wdata     <= 8'h00;
         r_rdata     <= 8'h00;
         r_err       <= RSP_OK;
         r_oe        <= 1'b0;
         r_lad       <= LAD_IDLE;
         r_lframe_n  <= 1'b1;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= 8'h00;
         r_rsp_err   <= RSP_OK;
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (ReqValid) begin
                  r_write     <= ReqWrite;
                  r_addr      <= ReqAddr;
                  r_wdata     <= ReqData;
                  r_rdata     <= 8'h00;
                  r_err       <= RSP_OK;
                  r_req_ready <= 1'b0;
                  r_lframe_n  <= 1'b0;
                  r_oe        <= 1'b1;
                  r_lad       <= LPC_START;
                  r_state     <= ST_START;
               end
            end
            ST_START: begin
               r_lframe_n <= 1'b1;
               r_lad      <= r_write ? CYC_IO_WR : CYC_IO_RD;
               r_state    <= ST_CYC;
            end
            ST_CYC: begin
               r_cnt   <= 3'd0;
               r_lad   <= addr_nibble(r_addr, 2'd0);
               r_state <= ST_ADDR;
            end
            ST_ADDR: begin
               if (r_cnt != 3'd3) begin
                  r_cnt <= r_cnt + 3'd1;
                  r_lad <= addr_nibble(r_addr, r_cnt[1:0] + 2'd1);
               end else if (r_write) begin
                  r_cnt   <= 3'd0;
                  r_lad   <= r_wdata[3:0];
                  r_state <= ST_WDATA;
               end else begin
                  r_lad   <= LAD_IDLE;
                  r_state <= ST_HTAR0;
               end
            end
            ST_WDATA: begin
               if (r_cnt == 3'd0) begin
                  r_cnt <= 3'd1;
                  r_lad <= r_wdata[7:4];
               end else begin
                  r_lad   <= LAD_IDLE;
                  r_state <= ST_HTAR0;
               end
            end
            ST_HTAR0: begin
               r_oe    <= 1'b0;
               r_state <= ST_HTAR1;
            end
            ST_HTAR1: r_state <= ST_SYNC;
            ST_SYNC: begin
               if (w_sync_fail) begin
                  r_err   <= RSP_TIMEOUT;
                  r_cnt   <= 3'd0;
                  r_oe    <= 1'b1;
                  r_lad   <= LAD_IDLE;
`ifdef LPC_HOST_ABORT_EN
                  r_lframe_n <= 1'b0;
`endif
                  r_state <= ST_FAIL;
               end else if ((LpcBus == SYNC_READY) || (LpcBus == SYNC_ERR)) begin
                  if (LpcBus == SYNC_ERR) r_err <= RSP_SYNC_ERR;
                  r_cnt   <= 3'd0;
                  r_state <= r_write ? ST_TTAR : ST_RDATA;
               end
            end
            ST_RDATA: begin
               if (r_cnt == 3'd0) begin
                  r_rdata[3:0] <= LpcBus;
                  r_cnt        <= 3'd1;
               end else begin
                  r_rdata[7:4] <= LpcBus;
                  r_cnt        <= 3'd0;
                  r_state      <= ST_TTAR;
               end
            end
            ST_TTAR: begin
               if (r_cnt == 3'd0) begin
                  r_cnt <= 3'd1;
               end else begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= r_err;
                  r_rsp_data  <= r_write ? 8'h00 : r_rdata;
                  r_state     <= ST_DONE;
               end
            end
            ST_FAIL: begin
`ifdef LPC_HOST_ABORT_EN
               // Four cycles of LFRAME# low with 4'hF, one high with 4'hF, one released
               if (r_cnt == 3'd3) r_lframe_n <= 1'b1;
               if (r_cnt == 3'd4) r_oe <= 1'b0;
               if (r_cnt != 3'd5) begin
                  r_cnt <= r_cnt + 3'd1;
               end else begin
`else
               // One cycle of 4'hF then one released cycle
               if (r_cnt == 3'd0) begin
                  r_oe  <= 1'b0;
                  r_cnt <= 3'd1;
               end else begin
`endif
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= r_err;
                  r_rsp_data  <= r_write ? 8'h00 : r_rdata;
                  r_state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_req_ready <= 1'b1;
               r_state     <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lpc_host_cycle.sv
// tb/tb_lpc_host_cycle.sv - directed self-checking bench for lpc_host_cycle
module tb_lpc_host_cycle;

   logic        LpcClock = 1'b0;
   logic        PciReset;
   logic        ReqValid;
   logic        ReqReady;
   logic        ReqWrite;
   logic [15:0] ReqAddr;
   logic [7:0]  ReqData;
   logic        RspValid;
   logic [7:0]  RspData;
   logic [1:0]  RspErr;
   logic        LFrameN;
   wire  [3:0]  LpcBus;

   logic        tgt_oe;
   logic [3:0]  tgt_lad;

   assign LpcBus = tgt_oe ? tgt_lad : 4'hz;
   pulldown (LpcBus[0]);
   pulldown (LpcBus[1]);
   pulldown (LpcBus[2]);
   pulldown (LpcBus[3]);

   always #15 LpcClock = ~LpcClock;

   lpc_host_cycle dut (
      .LpcClock (LpcClock),
      .PciReset (PciReset),
      .ReqValid (ReqValid),
      .ReqReady (ReqReady),
      .ReqWrite (ReqWrite),
      .ReqAddr  (ReqAddr),
      .ReqData  (ReqData),
      .RspValid (RspValid),
      .RspData  (RspData),
      .RspErr   (RspErr),
      .LFrameN  (LFrameN),
      .LpcBus   (LpcBus)
   );

`ifdef LPC_HOST_ABORT_EN
   localparam int FAIL_EXTRA = 6;
   localparam int ABORT_LOW  = 4;
`else
   localparam int FAIL_EXTRA = 2;
   localparam int ABORT_LOW  = 0;
`endif

   int checks;
   int errors;

   logic [3:0] script [0:31];
   int         slen;
   logic [3:0] tr_bus   [0:63];
   logic       tr_frame [0:63];
   logic       tr_ready [0:63];
   int         lat;
   int         pulses;
   logic [7:0] rdata;
   logic [1:0] rerr;

   // Issue one request and follow it cycle by cycle; cycle 1 is the cycle after the accept edge.
   // The target plays script[] starting in the first SYNC cycle, otherwise it releases the bus.
   task automatic run_xfer(input logic wr, input logic [15:0] addr, input logic [7:0] data);
      int sync_c;
      sync_c = wr ? 11 : 9;
      lat    = -1;
      pulses = 0;
      rdata  = 8'h00;
      rerr   = 2'b00;
      @(negedge LpcClock);
      ReqWrite = wr;
      ReqAddr  = addr;
      ReqData  = data;
      ReqValid = 1'b1;
      @(posedge LpcClock);
      #1;
      ReqValid = 1'b0;
      for (int c = 1; c < 64; c++) begin
         if (c >= sync_c && c < sync_c + slen) begin
            tgt_oe  = 1'b1;
            tgt_lad = script[c - sync_c];
         end else begin
            tgt_oe = 1'b0;
         end
         #1;
         tr_bus[c]   = LpcBus;
         tr_frame[c] = LFrameN;
         tr_ready[c] = ReqReady;
         if (RspValid) begin
            pulses++;
            if (lat < 0) begin
               lat   = c;
               rdata = RspData;
               rerr  = RspErr;
            end
         end
         if (lat > 0 && c >= lat + 2) break;
         @(posedge LpcClock);
         #1;
      end
      tgt_oe = 1'b0;
   endtask

   task automatic test_reset();
      PciReset = 1'b0;
      repeat (3) @(posedge LpcClock);
      @(negedge LpcClock);
      checks++; if (ReqReady !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ReqReady); end
      checks++; if (RspValid !== 1'b0) begin errors++; $display("FAIL reset_rspvalid: got %b expected 0", RspValid); end
      checks++; if (RspData !== 8'h00) begin errors++; $display("FAIL reset_rspdata: got %h expected 00", RspData); end
      checks++; if (RspErr !== 2'b00) begin errors++; $display("FAIL reset_rsperr: got %b expected 00", RspErr); end
      checks++; if (LFrameN !== 1'b1) begin errors++; $display("FAIL reset_lframe: got %b expected 1", LFrameN); end
      checks++; if (LpcBus !== 4'h0) begin errors++; $display("FAIL reset_bus_released: got %h expected pulled 0", LpcBus); end
      PciReset = 1'b1;
      repeat (2) @(negedge LpcClock);
   endtask

   task automatic test_io_read();
      logic [3:0] exp [1:8];
      exp = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'hE, 4'hF, 4'h0};
      script[0] = 4'h0; script[1] = 4'h3; script[2] = 4'hC; slen = 3;
      run_xfer(1'b0, 16'h002E, 8'h00);
      for (int c = 1; c <= 8; c++) begin
         checks++;
         if (tr_bus[c] !== exp[c]) begin errors++; $display("FAIL read_bus_c%0d: got %h expected %h", c, tr_bus[c], exp[c]); end
      end
      checks++; if (tr_frame[1] !== 1'b0) begin errors++; $display("FAIL read_lframe_start: got %b expected 0", tr_frame[1]); end
      checks++; if (tr_frame[2] !== 1'b1) begin errors++; $display("FAIL read_lframe_cyc: got %b expected 1", tr_frame[2]); end
      checks++; if (tr_ready[2] !== 1'b0) begin errors++; $display("FAIL read_busy_ready: got %b expected 0", tr_ready[2]); end
      checks++; if (lat !== 14) begin errors++; $display("FAIL read_latency: got %0d expected 14", lat); end
      checks++; if (rdata !== 8'hC3) begin errors++; $display("FAIL read_data: got %h expected c3", rdata); end
      checks++; if (rerr !== 2'b00) begin errors++; $display("FAIL read_err: got %b expected 00", rerr); end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL read_pulses: got %0d expected 1", pulses); end
      if (lat > 0) begin
         checks++; if (tr_ready[lat] !== 1'b0) begin errors++; $display("FAIL read_ready_done: got %b expected 0", tr_ready[lat]); end
         checks++; if (tr_ready[lat + 1] !== 1'b1) begin errors++; $display("FAIL read_ready_after: got %b expected 1", tr_ready[lat + 1]); end
      end
   endtask

   task automatic test_io_write();
      logic [3:0] exp [1:10];
      exp = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h8, 4'h0, 4'h5, 4'hA, 4'hF, 4'h0};
      script[0] = 4'h0; slen = 1;
      run_xfer(1'b1, 16'h0080, 8'hA5);
      for (int c = 1; c <= 10; c++) begin
         checks++;
         if (tr_bus[c] !== exp[c]) begin errors++; $display("FAIL write_bus_c%0d: got %h expected %h", c, tr_bus[c], exp[c]); end
      end
      checks++; if (lat !== 14) begin errors++; $display("FAIL write_latency: got %0d expected 14", lat); end
      checks++; if (rerr !== 2'b00) begin errors++; $display("FAIL write_err: got %b expected 00", rerr); end
      checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL write_rspdata: got %h expected 00", rdata); end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL write_pulses: got %0d expected 1", pulses); end
   endtask

   task automatic test_short_wait();
      // 6 short waits then ready, data 5A
      for (int i = 0; i < 6; i++) script[i] = 4'b0101;
      script[6] = 4'h0; script[7] = 4'hA; script[8] = 4'h5; slen = 9;
      run_xfer(1'b0, 16'h0060, 8'h00);
      checks++; if (lat !== 20) begin errors++; $display("FAIL wait6_latency: got %0d expected 20", lat); end
      checks++; if (rdata !== 8'h5A) begin errors++; $display("FAIL wait6_data: got %h expected 5a", rdata); end
      checks++; if (rerr !== 2'b00) begin errors++; $display("FAIL wait6_err: got %b expected 00", rerr); end
      // exactly the limit of 8 short waits is still fine
      for (int i = 0; i < 8; i++) script[i] = 4'b0101;
      script[8] = 4'h0; script[9] = 4'h1; script[10] = 4'h2; slen = 11;
      run_xfer(1'b0, 16'h0061, 8'h00);
      checks++; if (lat !== 22) begin errors++; $display("FAIL wait8_latency: got %0d expected 22", lat); end
      checks++; if (rdata !== 8'h21) begin errors++; $display("FAIL wait8_data: got %h expected 21", rdata); end
      // 8 short then 2 long: code change restarts the count
      for (int i = 0; i < 8; i++) script[i] = 4'b0101;
      script[8] = 4'b0110; script[9] = 4'b0110;
      script[10] = 4'h0; script[11] = 4'h4; script[12] = 4'h7; slen = 13;
      run_xfer(1'b0, 16'h0062, 8'h00);
      checks++; if (lat !== 24) begin errors++; $display("FAIL mixwait_latency: got %0d expected 24", lat); end
      checks++; if (rdata !== 8'h74) begin errors++; $display("FAIL mixwait_data: got %h expected 74", rdata); end
      checks++; if (rerr !== 2'b00) begin errors++; $display("FAIL mixwait_err: got %b expected 00", rerr); end
      // 9 short waits times out; last SYNC sample at cycle 17
      for (int i = 0; i < 9; i++) script[i] = 4'b0101;
      slen = 9;
      run_xfer(1'b0, 16'h0063, 8'h00);
      checks++; if (rerr !== 2'b10) begin errors++; $display("FAIL wait9_err: got %b expected 10", rerr); end
      checks++; if (lat !== 18 + FAIL_EXTRA) begin errors++; $display("FAIL wait9_latency: got %0d expected %0d", lat, 18 + FAIL_EXTRA); end
   endtask

   task automatic test_no_sync();
      int low;
      // three floating cycles are tolerated
      script[0] = 4'hF; script[1] = 4'hF; script[2] = 4'hF;
      script[3] = 4'h0; script[4] = 4'h8; script[5] = 4'h9; slen = 6;
      run_xfer(1'b0, 16'h0070, 8'h00);
      checks++; if (lat !== 17) begin errors++; $display("FAIL nosync3_latency: got %0d expected 17", lat); end
      checks++; if (rdata !== 8'h98) begin errors++; $display("FAIL nosync3_data: got %h expected 98", rdata); end
      // four floating cycles fail; last SYNC sample at cycle 12
      for (int i = 0; i < 4; i++) script[i] = 4'hF;
      slen = 4;
      run_xfer(1'b0, 16'h0071, 8'h00);
      checks++; if (rerr !== 2'b10) begin errors++; $display("FAIL nosync4_err: got %b expected 10", rerr); end
      checks++; if (lat !== 13 + FAIL_EXTRA) begin errors++; $display("FAIL nosync4_latency: got %0d expected %0d", lat, 13 + FAIL_EXTRA); end
      checks++; if (tr_bus[13] !== 4'hF) begin errors++; $display("FAIL nosync4_fail_bus: got %h expected f", tr_bus[13]); end
      low = 0;
      for (int c = 2; c <= 40; c++) if (tr_frame[c] === 1'b0 && (lat < 0 || c <= lat)) low++;
      checks++; if (low !== ABORT_LOW) begin errors++; $display("FAIL nosync4_lframe_low: got %0d expected %0d", low, ABORT_LOW); end
`ifdef LPC_HOST_ABORT_EN
      for (int c = 13; c <= 17; c++) begin
         checks++;
         if (tr_bus[c] !== 4'hF) begin errors++; $display("FAIL abort_bus_c%0d: got %h expected f", c, tr_bus[c]); end
      end
      checks++; if (tr_frame[17] !== 1'b1) begin errors++; $display("FAIL abort_lframe_c17: got %b expected 1", tr_frame[17]); end
`endif
   endtask

   task automatic test_sync_err();
      script[0] = 4'b1010; slen = 1;
      run_xfer(1'b1, 16'h03F8, 8'h11);
      checks++; if (rerr !== 2'b01) begin errors++; $display("FAIL syncerr_err: got %b expected 01", rerr); end
      checks++; if (lat !== 14) begin errors++; $display("FAIL syncerr_latency: got %0d expected 14", lat); end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL syncerr_pulses: got %0d expected 1", pulses); end
   endtask

   task automatic test_reset_mid_frame();
      int seen;
      @(negedge LpcClock);
      ReqWrite = 1'b0;
      ReqAddr  = 16'h002E;
      ReqData  = 8'h00;
      ReqValid = 1'b1;
      @(posedge LpcClock);
      #1;
      ReqValid = 1'b0;
      repeat (4) @(posedge LpcClock);
      #2;
      checks++; if (LpcBus !== 4'h2) begin errors++; $display("FAIL midrst_addr_nibble: got %h expected 2", LpcBus); end
      PciReset = 1'b0;
      #1;
      checks++; if (LFrameN !== 1'b1) begin errors++; $display("FAIL midrst_lframe: got %b expected 1", LFrameN); end
      checks++; if (LpcBus !== 4'h0) begin errors++; $display("FAIL midrst_bus_released: got %h expected pulled 0", LpcBus); end
      checks++; if (ReqReady !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", ReqReady); end
      repeat (2) @(negedge LpcClock);
      PciReset = 1'b1;
      seen = 0;
      repeat (20) begin
         @(negedge LpcClock);
         if (RspValid) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_rsp: got %0d pulses expected 0", seen); end
      script[0] = 4'h0; script[1] = 4'h9; script[2] = 4'h6; slen = 3;
      run_xfer(1'b0, 16'h002E, 8'h00);
      checks++; if (lat !== 14) begin errors++; $display("FAIL midrst_next_latency: got %0d expected 14", lat); end
      checks++; if (rdata !== 8'h69) begin errors++; $display("FAIL midrst_next_data: got %h expected 69", rdata); end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      PciReset = 1'b0;
      ReqValid = 1'b0;
      ReqWrite = 1'b0;
      ReqAddr  = 16'h0000;
      ReqData  = 8'h00;
      tgt_oe   = 1'b0;
      tgt_lad  = 4'h0;
      slen     = 0;
      test_reset();
      test_io_read();
      test_io_write();
      test_short_wait();
      test_no_sync();
      test_sync_err();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
